lsu_dma: RTL and testbench
==========================

// Module: lsu_dma
// PURPOSE
//  Block-transfer initiator for the data-memory LSU port. It drives the LSU's enable/mem_write/
//  addr/write_data and samples its read_data. It copies LEN words from SRC to DST, or fills LEN
//  words at DST with a constant, with no core involvement. It sits beside the Bitty core, which
//  kicks it with a one-cycle start pulse and polls busy/done.
// PARAMETERS
//  ADDR_W  16  width of src/dst pointers and mem_addr
//  DATA_W  16  width of data words, fill pattern and buffer
//  LEN_W   16  width of transfer length and words_done counter
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high
//  start        in   1       1-cycle request; sampled only in IDLE
//  mode_fill    in   1       0 = copy SRC->DST, 1 = fill DST with pattern
//  src          in   ADDR_W  copy source base address (word address)
//  dst          in   ADDR_W  destination base address
//  len          in   LEN_W   number of words to move
//  pattern      in   DATA_W  fill value
//  abort        in   1       stop after the current access
//  busy         out  1       high in any state other than IDLE
//  done         out  1       1-cycle pulse when a job ends (normal, zero-length or abort)
//  aborted      out  1       set with done if the job was aborted; held until the next start
//  words_done   out  LEN_W   words written in the current/last job; held until the next start
//  mem_en       out  1       -> LSU enable
//  mem_we       out  1       -> LSU mem_write
//  mem_addr     out  ADDR_W  -> LSU addr (LSU decodes addr[7:0] only; upper bits alias)
//  mem_wdata    out  DATA_W  -> LSU write_data
//  mem_rdata    in   DATA_W  <- LSU read_data; combinational, valid in the same cycle as en & !we
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; src_ptr, dst_ptr, remaining, buf cleared. A reset that
//    lands mid-job drops the job at once: no done pulse, and no further mem_en.
//  - mem_* outputs are Moore, decoded from the state and registers only. mem_en=0 in IDLE/DONE.
//  - Latching: on the start edge in IDLE, src/dst/len/pattern/mode_fill are captured.
//    words_done<=0 and aborted<=0 on that same edge.
//  - Zero length: start with len==0 goes IDLE->DONE. No memory access is made.
//  - start while busy is ignored.
//  - States:
//    IDLE -> RD (copy) | FL (fill) | DONE (len==0) on start.
//    RD: en=1, we=0, addr=src_ptr. buf<=mem_rdata at the edge. -> WR.
//    WR: en=1, we=1, addr=dst_ptr, wdata=buf. At the edge: src_ptr++, dst_ptr++, remaining--,
//        words_done++. -> DONE if remaining==1, else RD. Copy throughput is 2 cycles/word.
//    FL: en=1, we=1, addr=dst_ptr, wdata=pattern. At the edge: dst_ptr++, remaining--,
//        words_done++. -> DONE if remaining==1, else FL. Fill throughput is 1 cycle/word.
//    DONE: done=1 for exactly one cycle -> IDLE. busy is high in DONE.
//  - Latency: start edge to first mem_en is 1 cycle.
//    Copy of N words: done is asserted in cycle 2N+1 after the start edge.
//    Fill of N words: done is asserted in cycle N+1 after the start edge.
//  - Abort: sampled at the edge in RD, WR or FL. The access shown that cycle completes, then
//    the next state is DONE and aborted<=1. Abort in RD discards the read (no write follows).
//    Abort coinciding with the last write still sets aborted=1, and words_done=len.
//    Abort in IDLE/DONE is ignored.
//  - Arithmetic: pointers wrap modulo 2^ADDR_W (0xFFFF+1 = 0x0000). The counters do not wrap,
//    because remaining is always at most len.
//  - Overlap: copy is strictly forward, ascending addresses. With src<dst<src+len the source is
//    overwritten before it is read, by design. Software copies backward itself.
// STRUCTURE
//  - Package bitty_dma_pkg: typedef enum logic[2:0] dma_state_t {IDLE,RD,WR,FL,DONE}, and
//    localparams MODE_COPY=1'b0, MODE_FILL=1'b1.
//  - Single module, no sub-module. The datapath is 2 pointers, 1 down-counter, 1 up-counter and
//    1 buffer register.
// TESTING
//  - Bench uses a 256-word LSU model.
//  - Copy: mem[0x10..0x13]={A1,B2,C3,D4}; start src=0x10, dst=0x40, len=4 -> mem[0x40..0x43]
//    equal the source, words_done=4, done at cycle 9, aborted=0.
//  - Fill: start mode_fill=1, dst=0x80, len=3, pattern=0xBEEF -> mem[0x80..0x82]=0xBEEF,
//    done at cycle 4, mem[0x83] unchanged.
//  - Zero length and busy start: len=0 -> done 1 cycle after start, mem_en never high.
//    A second start while busy is ignored: dst region untouched.
//  - Abort: copy len=8, abort asserted in the 3rd WR cycle -> exactly 3 words written,
//    words_done=3, aborted=1, single done pulse.
//  - Wrap: fill dst=0xFFFE, len=4 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
//  - Reset mid-copy at cycle 3 -> all outputs 0 next cycle, no done pulse.
//    A new job then runs normally.

Source files
------------

// File: rtl/bitty_dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitty_dma_pkg : shared state encoding and mode constants for lsu_dma       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package bitty_dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FL   = 3'd3,
        DONE = 3'd4
    } dma_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lsu_dma_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_dma_if : data-memory LSU port; master = DMA initiator, slave = LSU     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface lsu_dma_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_dma : block copy / fill engine driving the data-memory LSU port         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lsu_dma
    import bitty_dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic              mode_fill,
    input  wire logic [ADDR_W-1:0] src,
    input  wire logic [ADDR_W-1:0] dst,
    input  wire logic [LEN_W-1:0]  len,
    input  wire logic [DATA_W-1:0] pattern,
    input  wire logic              abort,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [LEN_W-1:0]       words_done,
    lsu_dma_if.master              mem
);

    dma_state_t        state_q,      state_d;
    logic [ADDR_W-1:0] src_ptr_q,    src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q,    dst_ptr_d;
    logic [LEN_W-1:0]  remaining_q,  remaining_d;
    logic [LEN_W-1:0]  words_done_q, words_done_d;
    logic [DATA_W-1:0] buf_q,        buf_d;
    logic [DATA_W-1:0] pattern_q,    pattern_d;
    logic              aborted_q,    aborted_d;

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        words_done_d = words_done_q;
        buf_d        = buf_q;
        pattern_d    = pattern_q;
        aborted_d    = aborted_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_ptr_d    = src;
                    dst_ptr_d    = dst;
                    remaining_d  = len;
                    pattern_d    = pattern;
                    words_done_d = '0;
                    aborted_d    = 1'b0;
                    if (len == '0)
                        state_d = DONE;
                    else if (mode_fill == MODE_FILL)
                        state_d = FL;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                buf_d = mem.mem_rdata;
                // An aborted read is dropped: no matching write is issued.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = WR;
                end
            end
            WR, FL: begin
                if (state_q == WR)
                    src_ptr_d = src_ptr_q + ADDR_W'(1);
                dst_ptr_d    = dst_ptr_q + ADDR_W'(1);
                remaining_d  = remaining_q - LEN_W'(1);
                words_done_d = words_done_q + LEN_W'(1);
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (remaining_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = (state_q == WR) ? RD : FL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            buf_q        <= '0;
            pattern_q    <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            words_done_q <= words_done_d;
            buf_q        <= buf_d;
            pattern_q    <= pattern_d;
            aborted_q    <= aborted_d;
        end
    end

    // All outputs are pure decodes of registered state (Moore).
    always_comb begin
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        aborted       = aborted_q;
        words_done    = words_done_q;
        mem.mem_en    = (state_q == RD) || (state_q == WR) || (state_q == FL);
        mem.mem_we    = (state_q == WR) || (state_q == FL);
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state_q)
            RD:      mem.mem_addr = src_ptr_q;
            WR: begin
                mem.mem_addr  = dst_ptr_q;
                mem.mem_wdata = buf_q;
            end
            FL: begin
                mem.mem_addr  = dst_ptr_q;
                mem.mem_wdata = pattern_q;
            end
            default: begin
                mem.mem_addr  = '0;
                mem.mem_wdata = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_dma : lsu_dma against a 256-word LSU model and a job-level model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lsu_dma;
    import bitty_dma_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, mode_fill, abort;
    logic [ADDR_W-1:0] src, dst;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] pattern;
    logic              busy, done, aborted;
    logic [LEN_W-1:0]  words_done;

    always #5 clk = ~clk;

    lsu_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lsu_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode_fill  (mode_fill),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .pattern    (pattern),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_done (words_done),
        .mem        (bus)
    );

    // LSU model: 256 words, addr[7:0] decode, combinational read.
    logic [15:0] mem [256];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (bus.mem_en && bus.mem_we)
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    logic [15:0] ref_mem [256];

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_mem();
        for (int i = 0; i < 256; i++)
            check_val($sformatf("mem[%0d]", i), {16'h0, mem[i]}, {16'h0, ref_mem[i]});
    endtask

    // Called at a negedge with the DUT idle. abort_at = cycle after start in
    // which abort is held (0 = never).
    task automatic run_job(input bit fill, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] n, input logic [15:0] pat,
                           input int abort_at, input bit busy_start);
        acc_t exp_q[$];
        int   nat, limit, wcount;
        bit   exp_abort;
        logic [15:0] sa, da, v;
        nat       = (n == 0) ? 0 : (fill ? int'(n) : 2 * int'(n));
        exp_abort = (abort_at > 0) && (abort_at <= nat);
        limit     = exp_abort ? abort_at : nat;
        wcount    = 0;
        for (int k = 0; k < int'(n); k++) begin
            if (exp_q.size() >= limit) break;
            sa = s + 16'(k);
            da = d + 16'(k);
            if (!fill) begin
                exp_q.push_back('{1'b0, sa, 16'h0});
                if (exp_q.size() >= limit) break;
                v = ref_mem[sa[7:0]];
            end else begin
                v = pat;
            end
            exp_q.push_back('{1'b1, da, v});
            ref_mem[da[7:0]] = v;
            wcount++;
        end

        mode_fill = fill; src = s; dst = d; len = n; pattern = pat; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inputs after the start edge must have no effect.
        src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
        pattern = 16'($urandom); mode_fill = 1'($urandom);

        for (int c = 1; c <= limit + 2; c++) begin
            abort = (c == abort_at);
            start = busy_start && (c == 2) && (limit >= 1);
            if (c <= limit) begin
                check_val("mem_en", {31'h0, bus.mem_en}, 32'h1);
                check_val("mem_we", {31'h0, bus.mem_we}, {31'h0, exp_q[c-1].we});
                check_val("mem_addr", {16'h0, bus.mem_addr}, {16'h0, exp_q[c-1].addr});
                if (exp_q[c-1].we)
                    check_val("mem_wdata", {16'h0, bus.mem_wdata}, {16'h0, exp_q[c-1].wdata});
                check_val("busy", {31'h0, busy}, 32'h1);
                check_val("done", {31'h0, done}, 32'h0);
            end else if (c == limit + 1) begin
                check_val("mem_en_done", {31'h0, bus.mem_en}, 32'h0);
                check_val("done", {31'h0, done}, 32'h1);
                check_val("busy_done", {31'h0, busy}, 32'h1);
            end else begin
                check_val("mem_en_idle", {31'h0, bus.mem_en}, 32'h0);
                check_val("done_idle", {31'h0, done}, 32'h0);
                check_val("busy_idle", {31'h0, busy}, 32'h0);
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
        check_val("words_done", {16'h0, words_done}, 32'(wcount));
        check_val("aborted", {31'h0, aborted}, {31'h0, exp_abort});
        check_mem();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode_fill = 1'b0; abort = 1'b0;
        src = '0; dst = '0; len = '0; pattern = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) load_word(8'(i), 16'($urandom));
        check_val("rst_busy", {31'h0, busy}, 32'h0);
        check_val("rst_done", {31'h0, done}, 32'h0);
        check_val("rst_aborted", {31'h0, aborted}, 32'h0);
        check_val("rst_words", {16'h0, words_done}, 32'h0);
        check_val("rst_en", {31'h0, bus.mem_en}, 32'h0);
        check_val("rst_addr", {16'h0, bus.mem_addr}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        load_word(8'h10, 16'h00A1); load_word(8'h11, 16'h00B2);
        load_word(8'h12, 16'h00C3); load_word(8'h13, 16'h00D4);
        run_job(1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0, 0, 1'b0);
        run_job(1'b1, 16'h0000, 16'h0080, 16'd3, 16'hBEEF, 0, 1'b0);
        run_job(1'b0, 16'h0010, 16'h0050, 16'd0, 16'h0, 0, 1'b0);
        run_job(1'b0, 16'h0010, 16'h0058, 16'd4, 16'h0, 0, 1'b1);
        run_job(1'b0, 16'h0020, 16'h0090, 16'd8, 16'h0, 6, 1'b0);
        run_job(1'b0, 16'h0030, 16'h00A0, 16'd2, 16'h0, 4, 1'b0);
        run_job(1'b0, 16'h0030, 16'h00A8, 16'd3, 16'h0, 1, 1'b0);
        run_job(1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h1234, 0, 1'b0);
        run_job(1'b0, 16'h0012, 16'h0013, 16'd5, 16'h0, 0, 1'b0);

        // Reset in cycle 3 of a copy: only the first word has been written.
        mode_fill = 1'b0; src = 16'h0020; dst = 16'h0060; len = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        ref_mem[8'h60] = ref_mem[8'h20];
        @(negedge clk);
        check_val("mr_busy", {31'h0, busy}, 32'h0);
        check_val("mr_done", {31'h0, done}, 32'h0);
        check_val("mr_words", {16'h0, words_done}, 32'h0);
        check_val("mr_en", {31'h0, bus.mem_en}, 32'h0);
        check_val("mr_we", {31'h0, bus.mem_we}, 32'h0);
        check_val("mr_wdata", {16'h0, bus.mem_wdata}, 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("mr_no_done", {31'h0, done}, 32'h0);
            check_val("mr_no_en", {31'h0, bus.mem_en}, 32'h0);
        end
        run_job(1'b0, 16'h0020, 16'h0060, 16'd4, 16'h0, 0, 1'b0);

        for (int j = 0; j < 24; j++) begin
            bit          f;
            logic [15:0] n;
            int          ab;
            f  = 1'($urandom_range(0, 1));
            n  = 16'($urandom_range(0, 12));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * int'(n) + 2)) : 0;
            run_job(f, 16'($urandom), 16'($urandom), n, 16'($urandom), ab,
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
